// File: rtl/risc_wb_stage.sv
// Write-back stage: result select, late-load stall with bounded timeout, registered RF write.
// Define RISC_WB_FWD_EN to build the one-entry bypass register driving FWD_*.
module risc_wb_stage #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned ZERO_REG    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [2:0]        MD_1,
  input  logic              NxorV,
  input  logic [DATA_W-1:0] FUNC_OUT,
  input  logic [DATA_W-1:0] PC_LINK,
  input  logic [DATA_W-1:0] DATA_OUT,
  input  logic              DATA_VALID,
  input  logic              RW_1,
  input  logic [ADDR_W-1:0] DA_1,
  output logic [DATA_W-1:0] Bus_D,
  output logic              RW_OUT,
  output logic [ADDR_W-1:0] DA_OUT,
  output logic              OUT_VALID,
  output logic              ERR_TIMEOUT,
  output logic              FWD_VALID,
  output logic [ADDR_W-1:0] FWD_DA,
  output logic [DATA_W-1:0] FWD_DATA
);

  localparam int unsigned CntW      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit          ZeroRegEn = (ZERO_REG != 0);

  typedef enum logic {StIdle, StWaitMem} state_t;

  state_t            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [2:0]        hold_md_q;
  logic              hold_rw_q;
  logic [ADDR_W-1:0] hold_da_q;

  logic              in_wait, accept, commit, timeout, timeout_hit, wr_en;
  logic [2:0]        sel_md;
  logic              sel_rw;
  logic [ADDR_W-1:0] sel_da;

  function automatic logic is_load(input logic [2:0] md);
    return (md == 3'd1) || (md[2] == 1'b1);
  endfunction

  function automatic logic [DATA_W-1:0] form_data(input logic [2:0]        md,
                                                  input logic              nx,
                                                  input logic [DATA_W-1:0] fo,
                                                  input logic [DATA_W-1:0] pc,
                                                  input logic [DATA_W-1:0] dout);
    logic [DATA_W-1:0] r;
    case (md)
      3'd0:    r = fo;
      3'd1:    r = dout;
      3'd2:    r = {{(DATA_W-1){1'b0}}, nx};
      3'd3:    r = pc;
      3'd4:    r = {{(DATA_W-8){dout[7]}}, dout[7:0]};
      3'd5:    r = {{(DATA_W-8){1'b0}}, dout[7:0]};
      3'd6:    r = {{(DATA_W-16){dout[15]}}, dout[15:0]};
      default: r = {{(DATA_W-16){1'b0}}, dout[15:0]};
    endcase
    return r;
  endfunction

  // In WAIT_MEM the held fields steer the commit; live upstream inputs are ignored.
  always_comb begin
    in_wait     = (state_q == StWaitMem);
    IN_READY    = ~in_wait;
    sel_md      = in_wait ? hold_md_q : MD_1;
    sel_rw      = in_wait ? hold_rw_q : RW_1;
    sel_da      = in_wait ? hold_da_q : DA_1;
    accept      = IN_VALID & ~in_wait;
    timeout_hit = (MEM_TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == 32'(MEM_TIMEOUT));
    commit      = in_wait ? DATA_VALID : (accept & (~is_load(MD_1) | DATA_VALID));
    timeout     = in_wait & ~DATA_VALID & timeout_hit;
    wr_en       = commit & sel_rw & ~(ZeroRegEn & (sel_da == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hold_md_q   <= '0;
      hold_rw_q   <= 1'b0;
      hold_da_q   <= '0;
      Bus_D       <= '0;
      RW_OUT      <= 1'b0;
      DA_OUT      <= '0;
      OUT_VALID   <= 1'b0;
      ERR_TIMEOUT <= 1'b0;
    end else begin
      OUT_VALID   <= commit | timeout;
      ERR_TIMEOUT <= timeout;
      RW_OUT      <= wr_en;
      if (commit) begin
        Bus_D  <= form_data(sel_md, NxorV, FUNC_OUT, PC_LINK, DATA_OUT);
        DA_OUT <= sel_da;
      end
      case (state_q)
        StIdle: begin
          if (accept && is_load(MD_1) && !DATA_VALID) begin
            state_q   <= StWaitMem;
            cnt_q     <= '0;
            hold_md_q <= MD_1;
            hold_rw_q <= RW_1;
            hold_da_q <= DA_1;
          end
        end
        StWaitMem: begin
          cnt_q <= cnt_q + CntW'(1);
          if (commit || timeout) state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef RISC_WB_FWD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      FWD_VALID <= 1'b0;
      FWD_DA    <= '0;
      FWD_DATA  <= '0;
    end else if (wr_en) begin
      FWD_VALID <= 1'b1;
      FWD_DA    <= sel_da;
      FWD_DATA  <= form_data(sel_md, NxorV, FUNC_OUT, PC_LINK, DATA_OUT);
    end
  end
`else
  assign FWD_VALID = 1'b0;
  assign FWD_DA    = '0;
  assign FWD_DATA  = '0;
`endif

endmodule

// File: tb/tb_risc_wb_stage.sv
// Bench for risc_wb_stage: directed vector table, stall/timeout/reset sequences, random traffic.
module tb_risc_wb_stage;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned TMO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          IN_VALID, IN_READY, NxorV, DATA_VALID, RW_1;
  logic [2:0]    MD_1;
  logic [DW-1:0] FUNC_OUT, PC_LINK, DATA_OUT, Bus_D, FWD_DATA;
  logic [AW-1:0] DA_1, DA_OUT, FWD_DA;
  logic          RW_OUT, OUT_VALID, ERR_TIMEOUT, FWD_VALID;

  risc_wb_stage #(.DATA_W(DW), .ADDR_W(AW), .MEM_TIMEOUT(TMO), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .MD_1(MD_1),
    .NxorV(NxorV), .FUNC_OUT(FUNC_OUT), .PC_LINK(PC_LINK), .DATA_OUT(DATA_OUT),
    .DATA_VALID(DATA_VALID), .RW_1(RW_1), .DA_1(DA_1), .Bus_D(Bus_D), .RW_OUT(RW_OUT),
    .DA_OUT(DA_OUT), .OUT_VALID(OUT_VALID), .ERR_TIMEOUT(ERR_TIMEOUT),
    .FWD_VALID(FWD_VALID), .FWD_DA(FWD_DA), .FWD_DATA(FWD_DATA)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Bypass model: last committed write with an effective strobe.
  logic          m_fwd_v;
  logic [AW-1:0] m_fwd_da;
  logic [DW-1:0] m_fwd_data;

  typedef struct {
    logic [2:0]    md;
    logic          nx;
    logic [DW-1:0] fo;
    logic [DW-1:0] pc;
    logic [DW-1:0] dout;
    logic          dv;
    logic          rw;
    logic [AW-1:0] da;
    logic [DW-1:0] exp_bus;
    logic          exp_rw;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Result formation from the mode definitions using plain integer arithmetic.
  function automatic logic [DW-1:0] ref_data(input logic [2:0] md, input logic nx,
                                             input logic [DW-1:0] fo, input logic [DW-1:0] pc,
                                             input logic [DW-1:0] dout);
    int unsigned b, h;
    b = dout % 256;
    h = dout % 65536;
    case (md)
      3'd0: return fo;
      3'd1: return dout;
      3'd2: return nx ? 32'd1 : 32'd0;
      3'd3: return pc;
      3'd4: return (b >= 128) ? b - 256 : b;
      3'd5: return b;
      3'd6: return (h >= 32768) ? h - 65536 : h;
      default: return h;
    endcase
  endfunction

  task automatic check_fwd(input string nm);
`ifdef RISC_WB_FWD_EN
    check({nm, ".fwd_v"}, FWD_VALID, m_fwd_v);
    check({nm, ".fwd_da"}, FWD_DA, m_fwd_da);
    check({nm, ".fwd_data"}, FWD_DATA, m_fwd_data);
`else
    check({nm, ".fwd_v"}, FWD_VALID, 0);
    check({nm, ".fwd_da"}, FWD_DA, 0);
    check({nm, ".fwd_data"}, FWD_DATA, 0);
`endif
  endtask

  task automatic expect_commit(input string nm, input logic [DW-1:0] bus,
                               input logic [AW-1:0] da, input logic rw);
    logic erw;
    erw = rw && (da != 0);
    check({nm, ".out_valid"}, OUT_VALID, 1);
    check({nm, ".rw_out"}, RW_OUT, erw);
    check({nm, ".err"}, ERR_TIMEOUT, 0);
    check({nm, ".da_out"}, DA_OUT, da);
    check({nm, ".bus_d"}, Bus_D, bus);
    check({nm, ".ready"}, IN_READY, 1);
    if (erw) begin
      m_fwd_v = 1'b1; m_fwd_da = da; m_fwd_data = bus;
    end
    check_fwd(nm);
  endtask

  task automatic expect_quiet(input string nm);
    check({nm, ".out_valid"}, OUT_VALID, 0);
    check({nm, ".rw_out"}, RW_OUT, 0);
    check({nm, ".err"}, ERR_TIMEOUT, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    IN_VALID = 1'($urandom); MD_1 = 3'($urandom); DA_1 = AW'($urandom); RW_1 = 1'($urandom);
    FUNC_OUT = $urandom; PC_LINK = $urandom; NxorV = 1'($urandom); DATA_OUT = $urandom;
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, ".bus_d"}, Bus_D, 0);
    check({nm, ".da_out"}, DA_OUT, 0);
    check({nm, ".rw_out"}, RW_OUT, 0);
    check({nm, ".out_valid"}, OUT_VALID, 0);
    check({nm, ".err"}, ERR_TIMEOUT, 0);
    check({nm, ".ready"}, IN_READY, 1);
    check({nm, ".fwd_v"}, FWD_VALID, 0);
    check({nm, ".fwd_da"}, FWD_DA, 0);
    check({nm, ".fwd_data"}, FWD_DATA, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]    md;
    logic          rw, nx, dv;
    logic [AW-1:0] da;
    logic [DW-1:0] fo, pc, dout, exp;
    int            w;

    //             md  nx  fo            pc          dout          dv  rw  da  exp_bus       exp_rw
    vecs[0]  = '{3'd0, 0, 32'h0000_1234, 0,           0,            0,  1,  3, 32'h0000_1234, 1};
    vecs[1]  = '{3'd4, 0, 0,             0,           32'h0000_0080, 1, 1,  4, 32'hFFFF_FF80, 1};
    vecs[2]  = '{3'd7, 0, 0,             0,           32'h1234_8001, 1, 1,  6, 32'h0000_8001, 1};
    vecs[3]  = '{3'd2, 1, 32'hFFFF_FFFF, 0,           0,            0,  1,  2, 32'h0000_0001, 1};
    vecs[4]  = '{3'd3, 0, 0,             32'h0000_0400, 0,          0,  1, 31, 32'h0000_0400, 1};
    vecs[5]  = '{3'd5, 0, 0,             0,           32'hABCD_12F0, 1, 1,  8, 32'h0000_00F0, 1};
    vecs[6]  = '{3'd6, 0, 0,             0,           32'h0000_9001, 1, 1,  9, 32'hFFFF_9001, 1};
    vecs[7]  = '{3'd1, 0, 0,             0,           32'hCAFE_F00D, 1, 1, 10, 32'hCAFE_F00D, 1};
    vecs[8]  = '{3'd0, 0, 32'h0000_7777, 0,           0,            0,  1,  0, 32'h0000_7777, 0};
    vecs[9]  = '{3'd0, 0, 32'h0000_5555, 0,           32'h1111_1111, 1, 0, 11, 32'h0000_5555, 0};
    vecs[10] = '{3'd0, 0, 32'hA5A5_0000, 0,           0,            0,  1,  5, 32'hA5A5_0000, 1};
    vecs[11] = '{3'd3, 0, 0,             32'h0000_0BAD, 0,          0,  0, 12, 32'h0000_0BAD, 0};

    m_fwd_v = 1'b0; m_fwd_da = '0; m_fwd_data = '0;
    IN_VALID = 0; MD_1 = 0; NxorV = 0; FUNC_OUT = 0; PC_LINK = 0; DATA_OUT = 0;
    DATA_VALID = 0; RW_1 = 0; DA_1 = 0;
    rst = 1'b1;
    #3;
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back single-cycle commits from the vector table.
    for (int i = 0; i < 12; i++) begin
      MD_1 = vecs[i].md; NxorV = vecs[i].nx; FUNC_OUT = vecs[i].fo; PC_LINK = vecs[i].pc;
      DATA_OUT = vecs[i].dout; DATA_VALID = vecs[i].dv; RW_1 = vecs[i].rw; DA_1 = vecs[i].da;
      IN_VALID = 1'b1;
      step();
      check($sformatf("vec%0d.rw_out", i), RW_OUT, vecs[i].exp_rw);
      expect_commit($sformatf("vec%0d", i), vecs[i].exp_bus, vecs[i].da, vecs[i].rw);
    end
    IN_VALID = 0; DATA_VALID = 1;
    step();
    expect_quiet("idle_dv");
    check("idle.bus_hold", Bus_D, 32'h0000_0BAD);
    check_fwd("idle");

    // Late load: three stall cycles with upstream churn, then data.
    DATA_VALID = 0; MD_1 = 3'd1; DA_1 = 7; RW_1 = 1; IN_VALID = 1;
    step();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("wait%0d.ready", k), IN_READY, 0);
      expect_quiet($sformatf("wait%0d", k));
      scramble();
      DATA_VALID = 0;
      step();
    end
    check("wait3.ready", IN_READY, 0);
    IN_VALID = 1; MD_1 = 3'd0; DA_1 = 3; FUNC_OUT = 32'h1111_2222;
    DATA_VALID = 1; DATA_OUT = 32'hDEAD_BEEF;
    step();
    expect_commit("late_load", 32'hDEAD_BEEF, 7, 1);
    IN_VALID = 0; DATA_VALID = 0;
    step();
    expect_quiet("late_load.once");

    // Timeout: no data ever arrives.
    MD_1 = 3'd5; DA_1 = 13; RW_1 = 1; IN_VALID = 1;
    step();
    IN_VALID = 0;
    for (int k = 1; k <= int'(TMO); k++) begin
      if (IN_READY !== 1'b0 || ERR_TIMEOUT !== 1'b0 || OUT_VALID !== 1'b0) begin
        check($sformatf("tmo_wait%0d", k), {IN_READY, ERR_TIMEOUT, OUT_VALID}, 3'b000);
      end
      step();
    end
    check("tmo.err", ERR_TIMEOUT, 1);
    check("tmo.out_valid", OUT_VALID, 1);
    check("tmo.rw_out", RW_OUT, 0);
    check("tmo.ready", IN_READY, 1);
    check_fwd("tmo");
    step();
    expect_quiet("tmo.after");

    // Reset in the middle of a stall: abort, outputs cleared asynchronously.
    MD_1 = 3'd1; DA_1 = 14; RW_1 = 1; IN_VALID = 1; DATA_VALID = 0;
    step();
    IN_VALID = 0;
    step();
    check("prerst.ready", IN_READY, 0);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    m_fwd_v = 1'b0; m_fwd_da = '0; m_fwd_data = '0;
    #2 rst = 1'b0;
    DATA_VALID = 1; DATA_OUT = 32'h1234_5678;
    step();
    expect_quiet("rst_mid.nocommit");
    check("rst_mid.bus_d", Bus_D, 0);

    // Random traffic against the reference model.
    for (int t = 0; t < 80; t++) begin
      md = 3'($urandom); nx = 1'($urandom); fo = $urandom; pc = $urandom; dout = $urandom;
      rw = 1'($urandom); da = AW'($urandom_range(3, 0) == 0 ? 0 : $urandom);
      dv = 1'($urandom);
      if ($urandom_range(4, 0) == 0) begin
        IN_VALID = 0; DATA_VALID = dv; MD_1 = md; DATA_OUT = dout;
        step();
        expect_quiet($sformatf("rnd%0d.idle", t));
        continue;
      end
      MD_1 = md; NxorV = nx; FUNC_OUT = fo; PC_LINK = pc; DATA_OUT = dout;
      RW_1 = rw; DA_1 = da; DATA_VALID = dv; IN_VALID = 1;
      if ((md == 3'd1 || md >= 3'd4) && !dv) begin
        w = $urandom_range(5, 1);
        step();
        for (int k = 0; k < w; k++) begin
          check($sformatf("rnd%0d.stall%0d", t, k), {IN_READY, OUT_VALID}, 2'b00);
          scramble();
          DATA_VALID = (k == w - 1);
          dout = DATA_OUT;
          step();
        end
      end else begin
        step();
      end
      exp = ref_data(md, nx, fo, pc, dout);
      expect_commit($sformatf("rnd%0d", t), exp, da, rw);
      IN_VALID = 0; DATA_VALID = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
